// File: rtl/bringup_pkg.sv
// Shared state encodings, fail codes and helpers for the bring-up sequencer.
package bringup_pkg;

   typedef logic [2:0] state_t;

   localparam state_t StIdle     = 3'd0;
   localparam state_t StAdcRst   = 3'd1;
   localparam state_t StWaitLock = 3'd2;
   localparam state_t StDspRst   = 3'd3;
   localparam state_t StCoreRst  = 3'd4;
   localparam state_t StRun      = 3'd5;
   localparam state_t StPass     = 3'd6;
   localparam state_t StFail     = 3'd7;

   localparam logic [1:0] FAIL_NONE    = 2'd0;
   localparam logic [1:0] FAIL_LOCK    = 2'd1;
   localparam logic [1:0] FAIL_TIMEOUT = 2'd2;
   localparam logic [1:0] FAIL_ABORT   = 2'd3;

   typedef struct packed {
      logic adc;
      logic dsp;
      logic core;
      logic uart;
   } rst_vec_t;

   // Domain resets implied by a state; release order adc < dsp < core = uart.
   function automatic rst_vec_t rst_for_state(input state_t s);
      rst_vec_t r;
      r = '1;
      case (s)
         StWaitLock:     r = '{adc: 1'b0, dsp: 1'b1, core: 1'b1, uart: 1'b1};
         StDspRst:       r = '{adc: 1'b0, dsp: 1'b1, core: 1'b1, uart: 1'b1};
         StCoreRst:      r = '{adc: 1'b0, dsp: 1'b0, core: 1'b1, uart: 1'b1};
         StRun, StPass:  r = '0;
         default:        r = '1;
      endcase
      return r;
   endfunction

   function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/bringup_delay_timer.sv
// Loadable down-counter; expired_o pulses for one cycle when a loaded count of V
// has spent V cycles, so a state entered with a load lasts exactly V cycles.
module bringup_delay_timer #(
   parameter int unsigned W = 8
) (
   input  logic         core_clock,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] value_i,
   output logic         expired_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = value_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge core_clock) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == W'(1));

endmodule

// File: rtl/bringup_sequencer.sv
// Ordered domain reset release (ADC, DSP, core/UART) followed by a supervised run
// with success, cycle-budget and abort handling; all outputs registered.
module bringup_sequencer
   import bringup_pkg::*;
#(
   parameter int unsigned ADC_DLY  = 32,
   parameter int unsigned LOCK_TMO = 256,
   parameter int unsigned DSP_DLY  = 16,
   parameter int unsigned CORE_DLY = 64,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             core_clock,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] max_cycles,
   input  logic             adc_lock,
   input  logic             success,
   output logic             adc_reset_out,
   output logic             dsp_reset_out,
   output logic             core_reset_out,
   output logic             uart_reset_out,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [1:0]       fail_code,
   output logic [CNT_W-1:0] cycle_count
);

   // Core/UART hold is one cycle longer than the nominal delay.
   localparam int unsigned TmrMax = max4(ADC_DLY, LOCK_TMO, DSP_DLY, CORE_DLY + 1);
   localparam int unsigned TmrW   = $clog2(TmrMax) + 1;

   localparam logic [TmrW-1:0] AdcLoad  = TmrW'(ADC_DLY);
   localparam logic [TmrW-1:0] LockLoad = TmrW'(LOCK_TMO);
   localparam logic [TmrW-1:0] DspLoad  = TmrW'(DSP_DLY);
   localparam logic [TmrW-1:0] CoreLoad = TmrW'(CORE_DLY + 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] budget_q, budget_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [1:0]       code_q, code_d;
   rst_vec_t         rst_q, rst_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             fail_q, fail_d;

   logic            tmr_load;
   logic [TmrW-1:0] tmr_value;
   logic            tmr_expired;

   bringup_delay_timer #(
      .W(TmrW)
   ) u_timer (
      .core_clock(core_clock),
      .reset     (reset),
      .load_i    (tmr_load),
      .value_i   (tmr_value),
      .expired_o (tmr_expired)
   );

   always_comb begin
      state_d   = state_q;
      budget_d  = budget_q;
      count_d   = count_q;
      code_d    = code_q;
      tmr_load  = 1'b0;
      tmr_value = '0;

      case (state_q)
         StIdle, StPass, StFail: begin
            if (start) begin
               state_d   = StAdcRst;
               budget_d  = max_cycles;
               count_d   = '0;
               code_d    = FAIL_NONE;
               tmr_load  = 1'b1;
               tmr_value = AdcLoad;
            end
         end
         StAdcRst: begin
            if (abort) begin
               state_d = StFail;
               code_d  = FAIL_ABORT;
            end else if (tmr_expired) begin
               state_d   = StWaitLock;
               tmr_load  = 1'b1;
               tmr_value = LockLoad;
            end
         end
         StWaitLock: begin
            if (abort) begin
               state_d = StFail;
               code_d  = FAIL_ABORT;
            end else if (adc_lock) begin
               state_d   = StDspRst;
               tmr_load  = 1'b1;
               tmr_value = DspLoad;
            end else if (tmr_expired) begin
               state_d = StFail;
               code_d  = FAIL_LOCK;
            end
         end
         StDspRst: begin
            if (abort) begin
               state_d = StFail;
               code_d  = FAIL_ABORT;
            end else if (tmr_expired) begin
               state_d   = StCoreRst;
               tmr_load  = 1'b1;
               tmr_value = CoreLoad;
            end
         end
         StCoreRst: begin
            if (abort) begin
               state_d = StFail;
               code_d  = FAIL_ABORT;
            end else if (tmr_expired) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (count_q != '1) begin
               count_d = count_q + CNT_W'(1);
            end
            if (abort) begin
               state_d = StFail;
               code_d  = FAIL_ABORT;
            end else if (success) begin
               state_d = StPass;
            end else if ((budget_q != '0) && (count_q == budget_q - CNT_W'(1))) begin
               state_d = StFail;
               code_d  = FAIL_TIMEOUT;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Status is decoded from the next state so every output is a flop.
   always_comb begin
      rst_d  = rst_for_state(state_d);
      busy_d = (state_d != StIdle) && (state_d != StPass) && (state_d != StFail);
      done_d = (state_d == StPass) || (state_d == StFail);
      fail_d = (state_d == StFail);
   end

   always_ff @(posedge core_clock) begin
      if (!reset) begin
         state_q  <= StIdle;
         budget_q <= '0;
         count_q  <= '0;
         code_q   <= FAIL_NONE;
         rst_q    <= '1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         fail_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         budget_q <= budget_d;
         count_q  <= count_d;
         code_q   <= code_d;
         rst_q    <= rst_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         fail_q   <= fail_d;
      end
   end

   assign adc_reset_out  = rst_q.adc;
   assign dsp_reset_out  = rst_q.dsp;
   assign core_reset_out = rst_q.core;
   assign uart_reset_out = rst_q.uart;
   assign busy           = busy_q;
   assign done           = done_q;
   assign fail           = fail_q;
   assign fail_code      = code_q;
   assign cycle_count    = count_q;

endmodule

// File: tb/tb_bringup_sequencer.sv
// Scoreboard bench: expected outcomes are queued when a sequence is launched and
// popped when done rises; release edges are recorded and compared afterwards.
module tb_bringup_sequencer;
   import bringup_pkg::*;

   localparam int unsigned ADC_DLY  = 4;
   localparam int unsigned LOCK_TMO = 8;
   localparam int unsigned DSP_DLY  = 2;
   localparam int unsigned CORE_DLY = 3;
   localparam int unsigned CNT_W    = 32;

   logic             core_clock;
   logic             reset;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] max_cycles;
   logic             adc_lock;
   logic             success;
   logic             adc_reset_out, dsp_reset_out, core_reset_out, uart_reset_out;
   logic             busy, done, fail;
   logic [1:0]       fail_code;
   logic [CNT_W-1:0] cycle_count;

   bringup_sequencer #(
      .ADC_DLY (ADC_DLY),
      .LOCK_TMO(LOCK_TMO),
      .DSP_DLY (DSP_DLY),
      .CORE_DLY(CORE_DLY),
      .CNT_W   (CNT_W)
   ) dut (
      .core_clock    (core_clock),
      .reset         (reset),
      .start         (start),
      .abort         (abort),
      .max_cycles    (max_cycles),
      .adc_lock      (adc_lock),
      .success       (success),
      .adc_reset_out (adc_reset_out),
      .dsp_reset_out (dsp_reset_out),
      .core_reset_out(core_reset_out),
      .uart_reset_out(uart_reset_out),
      .busy          (busy),
      .done          (done),
      .fail          (fail),
      .fail_code     (fail_code),
      .cycle_count   (cycle_count)
   );

   typedef struct {
      string            tag;
      logic             fail;
      logic [1:0]       code;
      logic [CNT_W-1:0] count;
      int unsigned      at;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned cyc, k_edge;
   int unsigned n_checks, n_errs, order_errs;
   int unsigned adc_fall, dsp_fall, core_fall, uart_fall;
   logic        prev_adc, prev_dsp, prev_core, prev_uart, prev_done;

   initial core_clock = 1'b0;
   always #5 core_clock = ~core_clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input string tag, input logic f, input logic [1:0] code,
                           input logic [CNT_W-1:0] count, input int unsigned at);
      exp_t e;
      e.tag = tag; e.fail = f; e.code = code; e.count = count; e.at = at;
      exp_q.push_back(e);
   endtask

   // One clock edge; sample 1 time unit later, track release edges and done.
   task automatic tick();
      exp_t e;
      @(posedge core_clock);
      cyc++;
      #1;
      if (prev_adc && !adc_reset_out) adc_fall = cyc;
      if (prev_dsp && !dsp_reset_out) dsp_fall = cyc;
      if (prev_core && !core_reset_out) core_fall = cyc;
      if (prev_uart && !uart_reset_out) uart_fall = cyc;
      if ((!dsp_reset_out && adc_reset_out) || (!core_reset_out && dsp_reset_out) ||
          (core_reset_out != uart_reset_out)) order_errs++;
      if (done && !prev_done) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_done", done, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check_eq({e.tag, "_fail"}, fail, e.fail);
            check_eq({e.tag, "_code"}, fail_code, e.code);
            check_eq({e.tag, "_count"}, cycle_count, e.count);
            check_eq({e.tag, "_cycle"}, cyc, e.at);
         end
      end
      prev_adc  = adc_reset_out;
      prev_dsp  = dsp_reset_out;
      prev_core = core_reset_out;
      prev_uart = uart_reset_out;
      prev_done = done;
   endtask

   task automatic run_to(input int unsigned c);
      while (cyc < c) tick();
   endtask

   task automatic wait_done(input string tag, input int unsigned bound);
      for (int i = 0; i < bound && !done; i++) tick();
      check_eq({tag, "_done"}, done, 1'b1);
   endtask

   task automatic start_seq(input string tag, input logic [CNT_W-1:0] budget);
      adc_fall = 0; dsp_fall = 0; core_fall = 0; uart_fall = 0;
      max_cycles = budget;
      start = 1'b1;
      tick();
      start = 1'b0;
      k_edge = cyc;
      check_eq({tag, "_busy"}, busy, 1'b1);
      check_eq({tag, "_adc_held"}, adc_reset_out, 1'b1);
      check_eq({tag, "_core_held"}, core_reset_out, 1'b1);
      check_eq({tag, "_not_done"}, done, 1'b0);
   endtask

   initial begin
      cyc = 0; n_checks = 0; n_errs = 0; order_errs = 0;
      adc_fall = 0; dsp_fall = 0; core_fall = 0; uart_fall = 0;
      prev_adc = 1'b1; prev_dsp = 1'b1; prev_core = 1'b1; prev_uart = 1'b1; prev_done = 1'b0;
      reset = 1'b0; start = 1'b0; abort = 1'b0; max_cycles = '0;
      adc_lock = 1'b0; success = 1'b0;

      tick();
      tick();
      check_eq("rst_adc", adc_reset_out, 1'b1);
      check_eq("rst_dsp", dsp_reset_out, 1'b1);
      check_eq("rst_core", core_reset_out, 1'b1);
      check_eq("rst_uart", uart_reset_out, 1'b1);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_fail", fail, 1'b0);
      check_eq("rst_code", fail_code, FAIL_NONE);
      check_eq("rst_count", cycle_count, '0);
      reset = 1'b1;
      tick();

      // Abort while idle has no effect.
      abort = 1'b1;
      tick();
      tick();
      abort = 1'b0;
      check_eq("idle_abort_busy", busy, 1'b0);
      check_eq("idle_abort_fail", fail, 1'b0);
      check_eq("idle_abort_code", fail_code, FAIL_NONE);

      // Nominal: lock 5 cycles after ADC release, success on the 10th RUN cycle,
      // with stray start pulses during ADC_RST and RUN.
      start_seq("nominal", '0);
      push_exp("nominal", 1'b0, FAIL_NONE, 10, k_edge + 25);
      run_to(k_edge + 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      run_to(k_edge + 8);
      adc_lock = 1'b1;
      run_to(k_edge + 18);
      start = 1'b1;
      tick();
      start = 1'b0;
      run_to(k_edge + 24);
      success = 1'b1;
      wait_done("nominal", 20);
      success = 1'b0;
      adc_lock = 1'b0;
      check_eq("nominal_adc_edge", adc_fall, k_edge + 4);
      check_eq("nominal_dsp_edge", dsp_fall, k_edge + 11);
      check_eq("nominal_core_edge", core_fall, k_edge + 15);
      check_eq("nominal_uart_edge", uart_fall, k_edge + 15);
      check_eq("nominal_pass_core", core_reset_out, 1'b0);

      // Lock never arrives.
      start_seq("lock_tmo", '0);
      push_exp("lock_tmo", 1'b1, FAIL_LOCK, '0, k_edge + 4 + LOCK_TMO);
      wait_done("lock_tmo", 40);
      check_eq("lock_tmo_adc_edge", adc_fall, k_edge + 4);
      check_eq("lock_tmo_dsp_never", dsp_fall, 0);
      check_eq("lock_tmo_core_never", core_fall, 0);
      check_eq("lock_tmo_uart_never", uart_fall, 0);
      check_eq("lock_tmo_adc_reassert", adc_reset_out, 1'b1);

      // Budget of 20 with no success.
      adc_lock = 1'b1;
      start_seq("budget", 20);
      push_exp("budget", 1'b1, FAIL_TIMEOUT, 20, k_edge + 31);
      wait_done("budget", 60);
      check_eq("budget_core_edge", core_fall, k_edge + 11);
      check_eq("budget_core_reassert", core_reset_out, 1'b1);
      check_eq("budget_uart_reassert", uart_reset_out, 1'b1);

      // Success on the 20th RUN cycle beats the coincident timeout.
      start_seq("budget_ok", 20);
      push_exp("budget_ok", 1'b0, FAIL_NONE, 20, k_edge + 31);
      run_to(k_edge + 30);
      success = 1'b1;
      wait_done("budget_ok", 10);
      success = 1'b0;

      // Abort in DSP_RST.
      start_seq("abort", '0);
      push_exp("abort", 1'b1, FAIL_ABORT, '0, k_edge + 6);
      run_to(k_edge + 5);
      abort = 1'b1;
      wait_done("abort", 5);
      abort = 1'b0;
      check_eq("abort_adc", adc_reset_out, 1'b1);
      check_eq("abort_dsp", dsp_reset_out, 1'b1);
      check_eq("abort_uart", uart_reset_out, 1'b1);
      check_eq("abort_dsp_never", dsp_fall, 0);

      // Restart from FAIL runs to PASS.
      start_seq("restart", '0);
      push_exp("restart", 1'b0, FAIL_NONE, 5, k_edge + 16);
      run_to(k_edge + 15);
      success = 1'b1;
      wait_done("restart", 10);
      success = 1'b0;
      check_eq("restart_core_edge", core_fall, k_edge + 11);

      // Reset held one cycle in CORE_RST.
      start_seq("midrst", '0);
      run_to(k_edge + 8);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check_eq("midrst_adc", adc_reset_out, 1'b1);
      check_eq("midrst_dsp", dsp_reset_out, 1'b1);
      check_eq("midrst_core", core_reset_out, 1'b1);
      check_eq("midrst_busy", busy, 1'b0);
      check_eq("midrst_done", done, 1'b0);
      check_eq("midrst_fail", fail, 1'b0);
      run_to(k_edge + 16);
      check_eq("midrst_stays_idle", busy, 1'b0);
      check_eq("midrst_core_never", core_fall, 0);

      // Unlimited budget, success after 1000 RUN cycles.
      start_seq("long", '0);
      push_exp("long", 1'b0, FAIL_NONE, 1000, k_edge + 1011);
      run_to(k_edge + 1010);
      success = 1'b1;
      wait_done("long", 10);
      success = 1'b0;
      adc_lock = 1'b0;

      check_eq("release_order", order_errs, 0);
      check_eq("scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
